// File: rtl/mvm_pkg.sv
// mvm_pkg: shared element type, burst FSM states and default sizes for the MVM memories.
package mvm_pkg;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   typedef logic signed [DATA_W-1:0] elem_t;
   typedef enum logic [1:0] {IDLE, STREAM, DONE} strm_state_e;
endpackage

// File: rtl/vec_stream_ctrl.sv
// vec_stream_ctrl: burst sequencer choosing between random reads and wrapping stream reads.
module vec_stream_ctrl
   import mvm_pkg::*;
#(
   parameter int DEPTH  = mvm_pkg::DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              strm_start,
   input  logic [ADDR_W-1:0] strm_base,
   input  logic [ADDR_W:0]   strm_len,
   input  logic              strm_pause,
   output logic              issue,
   output logic [ADDR_W-1:0] addr,
   output logic              last,
   output logic              busy,
   output logic              done
);
   localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);
   strm_state_e state, next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0] cnt;
   always_comb begin
      next  = state;
      issue = 1'b0;
      addr  = rd_addr;
      last  = 1'b0;
      case (state)
         IDLE: begin
            if (strm_start) next = (strm_len == '0) ? DONE : STREAM;
            else issue = rd_en;
         end
         STREAM: begin
            issue = !strm_pause;
            addr  = ptr;
            last  = !strm_pause && cnt == (ADDR_W+1)'(1);
            if (last) next = DONE;
         end
         default: next = IDLE;
      endcase
   end
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= next;
         done  <= state == DONE;
         if (state == IDLE && strm_start) begin
            ptr <= strm_base;
            cnt <= strm_len;
         end else if (state == STREAM && !strm_pause) begin
            ptr <= (ptr == PTR_MAX) ? '0 : ptr + ADDR_W'(1);
            cnt <= cnt - (ADDR_W+1)'(1);
         end
      end
   end
endmodule

// File: rtl/vec_stream_mem.sv
// vec_stream_mem: vector storage with a write port and a registered read port fed
// either by random reads or by the wrapping burst sequencer.
module vec_stream_mem
   import mvm_pkg::*;
#(
   parameter int DATA_W = mvm_pkg::DATA_W,
   parameter int DEPTH  = mvm_pkg::DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic                     strm_start,
   input  logic [ADDR_W-1:0]        strm_base,
   input  logic [ADDR_W:0]          strm_len,
   input  logic                     strm_pause,
   output logic signed [DATA_W-1:0] rd_data,
   output logic                     rd_valid,
   output logic                     strm_busy,
   output logic                     strm_last,
   output logic                     strm_done
);
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   logic signed [DATA_W-1:0] mem [DEPTH];
   logic              issue, last;
   logic [ADDR_W-1:0] addr;
   vec_stream_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .strm_start (strm_start),
      .strm_base  (strm_base),
      .strm_len   (strm_len),
      .strm_pause (strm_pause),
      .issue      (issue),
      .addr       (addr),
      .last       (last),
      .busy       (strm_busy),
      .done       (strm_done)
   );
   // The read samples mem before this edge's write lands, giving read-first behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         strm_last <= 1'b0;
      end else begin
         if (wr_en && {1'b0, wr_addr} < DEPTH_W) mem[wr_addr] <= wr_data;
         if (issue) rd_data <= ({1'b0, addr} < DEPTH_W) ? mem[addr] : '0;
         rd_valid  <= issue;
         strm_last <= last;
      end
   end
endmodule

// File: tb/tb_vec_stream_mem.sv
// tb_vec_stream_mem: directed and randomized checks of vec_stream_mem against an array model.
module tb_vec_stream_mem;
   logic clk = 0, rst_n = 0;
   logic wr_en = 0, rd_en = 0, strm_start = 0, strm_pause = 0;
   logic [1:0] wr_addr = 0, rd_addr = 0, strm_base = 0;
   logic [2:0] strm_len = 0;
   logic signed [7:0] wr_data = 0, rd_data;
   logic rd_valid, strm_busy, strm_last, strm_done;
   logic signed [7:0] model [4];
   int checks = 0, errors = 0;

   vec_stream_mem dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .strm_start(strm_start), .strm_base(strm_base),
      .strm_len(strm_len), .strm_pause(strm_pause), .rd_data(rd_data), .rd_valid(rd_valid),
      .strm_busy(strm_busy), .strm_last(strm_last), .strm_done(strm_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, rd_valid, 0);
      chk({tag, "_busy"}, strm_busy, 0);
      chk({tag, "_last"}, strm_last, 0);
      chk({tag, "_done"}, strm_done, 0);
   endtask

   task automatic wr(input int a, input logic signed [7:0] d);
      wr_en = 1; wr_addr = a[1:0]; wr_data = d;
      tick();
      wr_en = 0;
      model[a] = d;
   endtask

   task automatic rd(input int a);
      rd_en = 1; rd_addr = a[1:0];
      tick();
      rd_en = 0;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, model[a]);
      tick();
      chk("rd_valid_drop", rd_valid, 0);
      chk("rd_data_hold", rd_data, model[a]);
   endtask

   task automatic load(input logic signed [7:0] a, b, c, d);
      wr(0, a); wr(1, b); wr(2, c); wr(3, d);
   endtask

   // Element k of a burst is model[(base+k) % 4]; a paused stream cycle yields no data.
   task automatic burst(input int base, input int len, input logic [63:0] pmask);
      int issued = 0, k = 0;
      strm_start = 1; strm_base = base[1:0]; strm_len = len[2:0];
      rd_en = 1; rd_addr = 2'($urandom);
      tick();
      rd_en = 0; strm_start = 0;
      chk("start_busy", strm_busy, 1);
      chk("start_valid", rd_valid, 0);
      if (len == 0) begin
         tick();
         chk("len0_busy", strm_busy, 0);
         chk("len0_done", strm_done, 1);
         chk("len0_valid", rd_valid, 0);
      end else begin
         while (issued < len && k < 64) begin
            strm_pause = pmask[k];
            strm_start = 1'($urandom); strm_base = 2'($urandom); strm_len = 3'($urandom_range(1, 7));
            rd_en = 1'($urandom); rd_addr = 2'($urandom);
            tick();
            chk("s_valid", rd_valid, !pmask[k]);
            chk("s_done", strm_done, 0);
            chk("s_busy", strm_busy, 1);
            if (!pmask[k]) begin
               chk("s_data", rd_data, model[(base + issued) % 4]);
               chk("s_last", strm_last, issued == len - 1);
               issued++;
            end else chk("s_last_gap", strm_last, 0);
            k++;
         end
         chk("burst_bound", issued, len);
         strm_pause = 0; strm_start = 0; rd_en = 0;
         tick();
         chk("end_done", strm_done, 1);
         chk("end_busy", strm_busy, 0);
         chk("end_valid", rd_valid, 0);
         chk("end_last", strm_last, 0);
      end
      tick();
      chk("post_done", strm_done, 0);
      chk("post_busy", strm_busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) model[i] = 0;
      tick(); tick();
      chk_idle("rst");
      chk("rst_data", rd_data, 0);
      rst_n = 1;
      tick();
      load(5, -3, 7, 12);
      rd(1);
      rd(3);
      // Asynchronous reset mid-cycle clears outputs and storage at once.
      rd_en = 1; rd_addr = 3;
      tick();
      rd_en = 0;
      chk("pre_rst_valid", rd_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("async_valid", rd_valid, 0);
      chk("async_data", rd_data, 0);
      rst_n = 1;
      for (int i = 0; i < 4; i++) model[i] = 0;
      tick();
      for (int i = 0; i < 4; i++) rd(i);
      // Read-first collision.
      load(5, -3, 7, 12);
      wr_en = 1; wr_addr = 2; wr_data = 9; rd_en = 1; rd_addr = 2;
      tick();
      wr_en = 0; rd_en = 0;
      chk("collide_valid", rd_valid, 1);
      chk("collide_old", rd_data, 7);
      model[2] = 9;
      rd(2);
      load(5, -3, 7, 12);
      burst(2, 4, 64'h0);
      burst(0, 3, 64'b110);
      burst(1, 0, 64'h0);
      // Abort a burst with reset: no done pulse, storage cleared.
      strm_start = 1; strm_base = 0; strm_len = 4;
      tick();
      strm_start = 0;
      tick();
      #2 rst_n = 0;
      #1;
      chk("abort_busy", strm_busy, 0);
      chk("abort_valid", rd_valid, 0);
      rst_n = 1;
      for (int i = 0; i < 4; i++) model[i] = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("abort_quiet");
      end
      load(5, -3, 7, 12);
      burst(0, 6, 64'h0);
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 1)) wr(i, 8'($urandom));
         rd($urandom_range(0, 3));
         burst($urandom_range(0, 3), $urandom_range(0, 7), {$urandom, $urandom} & {$urandom, $urandom});
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
